fpu_hazard_ctrl: RTL and testbench
==================================

Name: fpu_hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core with a non-pipelined multi-cycle FPU.
- Drives the stall and flush inputs of the IF/ID and ID/EX registers and the E-stage forwarding muxes.
- Tracks the single in-flight FPU operation to stall on RAW and structural hazards.
- Keeps saturating stall and flush statistics counters.

Parameters:
- TAG_W, 6, register tag width: {isFP, idx[4:0]}; tag 0 = x0 (never hazards); tag 32 = f0 (real register).
- LAT_W, 4, width of the FPU latency field.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Rs1D, Rs2D, Rs3D  in  TAG_W  D-stage source tags; Rs3D is used only by FMA
- fpuOpD  in  1  instruction in D is a multi-cycle FPU op
- Rs1E, Rs2E, RdE  in  TAG_W  E-stage tags
- LoadE  in  1  instruction in E is a load
- PCSrcE  in  1  taken branch or jump resolved in E
- fpuStartE  in  1  FPU op in E issues this cycle
- fpuRdE  in  TAG_W  destination of the issuing FPU op
- fpuLatE  in  LAT_W  cycles until its result; 0 is treated as 1
- RdM, RdW  in  TAG_W  M- and W-stage destination tags
- RegWriteM, RegWriteW  in  1  write enables for M and W
- StallF, StallD, FlushD, FlushE  out  1  pipeline register control
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = from M, 01 = from W
- fpuBusy  out  1  FPU op in flight
- fpuDone  out  1  one-cycle pulse on the last busy cycle
- protoErr  out  1  sticky: fpuStartE asserted while fpuBusy
- stallCnt, flushCnt  out  CNT_W  saturating event counters

Behaviour:
- Reset (async, reset=0): busyCnt=0, busyRd=0, fpuBusy=0, fpuDone=0, protoErr=0, stallCnt=0, flushCnt=0. Combinational outputs then evaluate with busy=0.
- Forwarding (combinational), applied per source (Rs1E→ForwardAE, Rs2E→ForwardBE):
  - 10 if RegWriteM, RdM≠0 and RdM==source.
  - else 01 if RegWriteW, RdW≠0 and RdW==source.
  - else 00. M takes priority over W.
- lwStall = LoadE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D | RdE==Rs3D).
- fpuStall = fpuBusy & ((busyRd≠0 & busyRd∈{Rs1D,Rs2D,Rs3D}) | fpuOpD). The second term is the structural hazard.
- StallF = StallD = lwStall | fpuStall.
- FlushD = PCSrcE.
- FlushE = lwStall | fpuStall | PCSrcE. A flush overrides a stall in ID/EX.
- FPU tracker is a 2-state FSM, IDLE/BUSY, with fpuBusy = (busyCnt≠0):
  - IDLE & fpuStartE: busyCnt ← max(fpuLatE,1), busyRd ← fpuRdE → BUSY.
  - BUSY: busyCnt decrements each cycle; fpuDone is registered and high in the cycle busyCnt==1; then → IDLE.
  - fpuStartE while BUSY: ignored and protoErr ← 1. protoErr stays set until reset.
  - fpuStartE in the same cycle as the done pulse (busyCnt==1) counts as BUSY: it is ignored and sets protoErr.
- Hazard evaluation uses the registered busy state. On the done cycle the stall still holds; D is released the next cycle.
- PCSrcE does not cancel an in-flight FPU op. An op already issued completes.
- stallCnt +1 on every cycle StallD=1. flushCnt +1 on every cycle FlushD=1. Both saturate at all-ones with no wrap.
- No outputs depend on clk other than the registered tracker state and counters.

Test Plan:
- Reset mid-BUSY (busyCnt=3) → fpuBusy=0 and both counters 0 immediately, without waiting for clk; next cycle StallD=0 with Rs1D=busyRd.
- RdM=RdW=5, both RegWrite=1, Rs1E=5 → ForwardAE=10. Then RegWriteM=0 → ForwardAE=01. Then Rs1E=0 with RdM=0 → 00.
- LoadE=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle, FlushD=0, stallCnt=1. With RdE=0 instead → no stall.
- fpuStartE with fpuLatE=4, fpuRdE=33, then Rs1D=33 held in D → exactly 4 stall cycles; fpuDone high on the 4th; StallD=0 on the 5th.
- BUSY with Rs1D=40 unrelated and fpuOpD=1 → structural stall. Assert fpuStartE mid-BUSY → protoErr=1, and it stays set.
- PCSrcE=1 while lwStall=1 → FlushD=1, FlushE=1, StallD=1. After 65540 forced stall cycles → stallCnt=65535, saturated.

Source files
------------

// File: rtl/fpu_hazard_ctrl.sv
// ============================================================================
//  Module      : fpu_hazard_ctrl
//  Description : Hazard, forwarding and multi-cycle FPU sequencing control
//                for a 5-stage core, with saturating stall/flush counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_hazard_ctrl #(
   parameter int TAG_W = 6,
   parameter int LAT_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [TAG_W-1:0] Rs1D,
   input  logic [TAG_W-1:0] Rs2D,
   input  logic [TAG_W-1:0] Rs3D,
   input  logic             fpuOpD,
   input  logic [TAG_W-1:0] Rs1E,
   input  logic [TAG_W-1:0] Rs2E,
   input  logic [TAG_W-1:0] RdE,
   input  logic             LoadE,
   input  logic             PCSrcE,
   input  logic             fpuStartE,
   input  logic [TAG_W-1:0] fpuRdE,
   input  logic [LAT_W-1:0] fpuLatE,
   input  logic [TAG_W-1:0] RdM,
   input  logic [TAG_W-1:0] RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             fpuBusy,
   output logic             fpuDone,
   output logic             protoErr,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [LAT_W-1:0] r_busyCnt;
   logic [LAT_W-1:0] w_nextCnt;
   logic [TAG_W-1:0] r_busyRd;
   logic [TAG_W-1:0] w_nextRd;
   logic             w_protoSet;
   logic             r_fpuDone;
   logic             r_protoErr;
   logic [CNT_W-1:0] r_stallCnt;
   logic [CNT_W-1:0] r_flushCnt;
   logic             w_lwStall;
   logic             w_fpuStall;
   logic             w_busy;

   // M result is younger than W, so it wins when both match.
   function automatic logic [1:0] fwdSel(input logic [TAG_W-1:0] src);
      if (RegWriteM && (RdM != '0) && (RdM == src))
         return 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign ForwardAE = fwdSel(Rs1E);
   assign ForwardBE = fwdSel(Rs2E);

   assign w_busy     = (r_busyCnt != '0);
   assign w_lwStall  = LoadE && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D) || (RdE == Rs3D));
   // Second term is the structural hazard: only one FPU op may be in flight.
   assign w_fpuStall = w_busy &&
                       (((r_busyRd != '0) &&
                         ((r_busyRd == Rs1D) || (r_busyRd == Rs2D) || (r_busyRd == Rs3D)))
                        || fpuOpD);

   assign StallF    = w_lwStall | w_fpuStall;
   assign StallD    = w_lwStall | w_fpuStall;
   assign FlushD    = PCSrcE;
   assign FlushE    = w_lwStall | w_fpuStall | PCSrcE;
   assign fpuBusy   = w_busy;
   assign fpuDone   = r_fpuDone;
   assign protoErr  = r_protoErr;
   assign stallCnt  = r_stallCnt;
   assign flushCnt  = r_flushCnt;

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_busyCnt;
      w_nextRd    = r_busyRd;
      w_protoSet  = 1'b0;
      case (r_state)
         IDLE: begin
            if (fpuStartE) begin
               w_nextCnt   = (fpuLatE == '0) ? LAT_W'(1) : fpuLatE;
               w_nextRd    = fpuRdE;
               w_nextState = BUSY;
            end
         end
         BUSY: begin
            // A start arriving on the done cycle is still a protocol error.
            w_nextCnt  = r_busyCnt - LAT_W'(1);
            w_protoSet = fpuStartE;
            if (r_busyCnt == LAT_W'(1))
               w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_busyCnt  <= '0;
         r_busyRd   <= '0;
         r_fpuDone  <= 1'b0;
         r_protoErr <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_busyCnt  <= w_nextCnt;
         r_busyRd   <= w_nextRd;
         r_fpuDone  <= (w_nextCnt == LAT_W'(1));
         r_protoErr <= r_protoErr | w_protoSet;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if (StallD && (r_stallCnt != '1))
            r_stallCnt <= r_stallCnt + CNT_W'(1);
         if (FlushD && (r_flushCnt != '1))
            r_flushCnt <= r_flushCnt + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fpu_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_fpu_hazard_ctrl
//  Description : Directed scoreboard bench for fpu_hazard_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpu_hazard_ctrl;
   localparam int TAG_W = 6;
   localparam int LAT_W = 4;
   localparam int CNT_W = 16;

   localparam logic [10:0] MK_HZ  = 11'b11110000000;
   localparam logic [10:0] MK_FWD = 11'b00001111000;
   localparam logic [10:0] MK_ALL = 11'b11111111111;

   logic             clk = 1'b0;
   logic             reset;
   logic [TAG_W-1:0] Rs1D, Rs2D, Rs3D, Rs1E, Rs2E, RdE, fpuRdE, RdM, RdW;
   logic             fpuOpD, LoadE, PCSrcE, fpuStartE, RegWriteM, RegWriteW;
   logic [LAT_W-1:0] fpuLatE;
   logic             StallF, StallD, FlushD, FlushE, fpuBusy, fpuDone, protoErr;
   logic [1:0]       ForwardAE, ForwardBE;
   logic [CNT_W-1:0] stallCnt, flushCnt;
   logic [10:0]      obs;

   always #5 clk = ~clk;

   fpu_hazard_ctrl #(.TAG_W(TAG_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs3D(Rs3D), .fpuOpD(fpuOpD),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .LoadE(LoadE), .PCSrcE(PCSrcE),
      .fpuStartE(fpuStartE), .fpuRdE(fpuRdE), .fpuLatE(fpuLatE),
      .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .fpuBusy(fpuBusy), .fpuDone(fpuDone), .protoErr(protoErr),
      .stallCnt(stallCnt), .flushCnt(flushCnt)
   );

   assign obs = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, fpuBusy, fpuDone, protoErr};

   typedef struct {
      string       name;
      logic [10:0] ctl;
      logic [10:0] mask;
      bit          isCnt;
      logic [15:0] s;
      logic [15:0] f;
   } exp_t;

   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [10:0] ctl(input logic sf, input logic sd, input logic fd,
                                       input logic fe, input logic [1:0] fa, input logic [1:0] fb,
                                       input logic busy, input logic done, input logic pe);
      return {sf, sd, fd, fe, fa, fb, busy, done, pe};
   endfunction

   task automatic expCtl(input string n, input logic [10:0] c, input logic [10:0] m);
      exp_t e;
      e.name = n; e.ctl = c; e.mask = m; e.isCnt = 1'b0; e.s = '0; e.f = '0;
      sbQ.push_back(e);
   endtask

   task automatic expCnt(input string n, input logic [15:0] s, input logic [15:0] f);
      exp_t e;
      e.name = n; e.ctl = '0; e.mask = '0; e.isCnt = 1'b1; e.s = s; e.f = f;
      sbQ.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      Rs1D = '0; Rs2D = '0; Rs3D = '0; fpuOpD = 1'b0;
      Rs1E = '0; Rs2E = '0; RdE = '0; LoadE = 1'b0; PCSrcE = 1'b0;
      fpuStartE = 1'b0; fpuRdE = '0; fpuLatE = '0;
      RdM = '0; RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
   endtask

   // Monitor: compares every queued expectation against the settled outputs.
   initial begin
      forever begin
         @(negedge clk);
         while (sbQ.size() > 0) begin
            exp_t e;
            e = sbQ.pop_front();
            checks++;
            if (e.isCnt) begin
               if (stallCnt !== e.s || flushCnt !== e.f) begin
                  errors++;
                  $display("FAIL %s: stallCnt=%0d flushCnt=%0d, expected stallCnt=%0d flushCnt=%0d",
                           e.name, stallCnt, flushCnt, e.s, e.f);
               end
            end else if ((obs & e.mask) !== (e.ctl & e.mask)) begin
               errors++;
               $display("FAIL %s: got %b, expected %b (mask %b)", e.name, obs, e.ctl, e.mask);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      clr();
      reset = 1'b0;
      cyc();
      expCtl("rstCtl", '0, MK_ALL);
      expCnt("rstCnt", 16'd0, 16'd0);
      cyc(); reset = 1'b1;

      // Forwarding
      cyc(); RdM = 6'd5; RdW = 6'd5; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 6'd5; Rs2E = 6'd5;
      expCtl("fwdM", ctl(0,0,0,0,2'b10,2'b10,0,0,0), MK_FWD | MK_HZ);
      cyc(); RegWriteM = 1'b0;
      expCtl("fwdW", ctl(0,0,0,0,2'b01,2'b01,0,0,0), MK_FWD);
      cyc(); RegWriteM = 1'b1; RdM = 6'd0; Rs1E = 6'd0; Rs2E = 6'd6;
      expCtl("fwdNone", ctl(0,0,0,0,2'b00,2'b00,0,0,0), MK_FWD);
      cyc(); RdM = 6'd32; Rs1E = 6'd32; RdW = 6'd5; Rs2E = 6'd5;
      expCtl("fwdF0Mix", ctl(0,0,0,0,2'b10,2'b01,0,0,0), MK_FWD);
      cyc(); RdM = 6'd0; RdW = 6'd0; Rs1E = 6'd0; Rs2E = 6'd0;
      expCtl("fwdX0", ctl(0,0,0,0,2'b00,2'b00,0,0,0), MK_FWD);

      // Load-use
      cyc(); clr(); LoadE = 1'b1; RdE = 6'd7; Rs2D = 6'd7;
      expCtl("lwStall", ctl(1,1,0,1,0,0,0,0,0), MK_ALL);
      cyc(); clr();
      expCtl("lwRelease", '0, MK_ALL);
      expCnt("lwCnt", 16'd1, 16'd0);
      cyc(); LoadE = 1'b1; RdE = 6'd0; Rs2D = 6'd7;
      expCtl("lwX0", '0, MK_HZ);
      cyc(); clr(); LoadE = 1'b1; RdE = 6'd9; Rs3D = 6'd9;
      expCtl("lwRs3", ctl(1,1,0,1,0,0,0,0,0), MK_HZ);
      cyc(); clr();
      expCnt("lwCnt2", 16'd2, 16'd0);

      // FPU RAW, latency 4
      cyc(); fpuStartE = 1'b1; fpuLatE = 4'd4; fpuRdE = 6'd33; Rs1D = 6'd33;
      expCtl("fpuIssue", '0, MK_ALL);
      cyc(); fpuStartE = 1'b0;
      expCtl("fpuRaw1", ctl(1,1,0,1,0,0,1,0,0), MK_ALL);
      cyc(); expCtl("fpuRaw2", ctl(1,1,0,1,0,0,1,0,0), MK_ALL);
      cyc(); expCtl("fpuRaw3", ctl(1,1,0,1,0,0,1,0,0), MK_ALL);
      cyc(); expCtl("fpuRaw4Done", ctl(1,1,0,1,0,0,1,1,0), MK_ALL);
      cyc(); expCtl("fpuRawRel", '0, MK_ALL);
      expCnt("fpuRawCnt", 16'd6, 16'd0);

      // Asynchronous reset while busy
      cyc(); clr(); fpuStartE = 1'b1; fpuLatE = 4'd5; fpuRdE = 6'd36; Rs1D = 6'd36;
      cyc(); fpuStartE = 1'b0;
      expCtl("busy5", ctl(1,1,0,1,0,0,1,0,0), MK_ALL);
      cyc();
      cyc(); reset = 1'b0;
      expCtl("rstAsync", '0, MK_ALL);
      expCnt("rstAsyncCnt", 16'd0, 16'd0);
      cyc(); reset = 1'b1;
      expCtl("postRst", '0, MK_ALL);

      // Latency 0 and start on the done cycle
      cyc(); clr(); fpuStartE = 1'b1; fpuLatE = 4'd0; fpuRdE = 6'd35;
      expCtl("lat0Issue", '0, MK_ALL);
      cyc(); fpuLatE = 4'd2; fpuRdE = 6'd37;
      expCtl("lat0Done", ctl(0,0,0,0,0,0,1,1,0), MK_ALL);
      cyc(); fpuStartE = 1'b0;
      expCtl("doneStartErr", ctl(0,0,0,0,0,0,0,0,1), MK_ALL);
      cyc(); expCtl("perrSticky", ctl(0,0,0,0,0,0,0,0,1), MK_ALL);
      cyc(); reset = 1'b0;
      expCtl("perrRst", '0, MK_ALL);
      cyc(); reset = 1'b1;
      expCtl("perrRstRel", '0, MK_ALL);

      // Structural hazard and mid-busy start
      cyc(); fpuStartE = 1'b1; fpuLatE = 4'd3; fpuRdE = 6'd34; Rs1D = 6'd40; fpuOpD = 1'b1;
      expCtl("structIssue", '0, MK_ALL);
      cyc(); fpuStartE = 1'b0;
      expCtl("structStall", ctl(1,1,0,1,0,0,1,0,0), MK_ALL);
      cyc(); fpuOpD = 1'b0; fpuStartE = 1'b1; fpuLatE = 4'd7; fpuRdE = 6'd40;
      expCtl("midStart", ctl(0,0,0,0,0,0,1,0,0), MK_ALL);
      cyc(); fpuStartE = 1'b0; Rs2D = 6'd34;
      expCtl("doneHoldStall", ctl(1,1,0,1,0,0,1,1,1), MK_ALL);
      cyc(); expCtl("ignoredStart", ctl(0,0,0,0,0,0,0,0,1), MK_ALL);
      cyc(); clr();
      expCnt("structCnt", 16'd2, 16'd0);

      // Branch flush combined with load-use
      cyc(); LoadE = 1'b1; RdE = 6'd7; Rs1D = 6'd7; PCSrcE = 1'b1;
      expCtl("flushStall", ctl(1,1,1,1,0,0,0,0,1), MK_ALL);
      cyc(); clr(); PCSrcE = 1'b1;
      expCtl("flushOnly", ctl(0,0,1,1,0,0,0,0,1), MK_ALL);
      cyc(); clr();
      expCnt("flushCnt", 16'd3, 16'd2);

      // Flush does not cancel an FPU op
      cyc(); fpuStartE = 1'b1; fpuLatE = 4'd2; fpuRdE = 6'd38;
      cyc(); fpuStartE = 1'b0; PCSrcE = 1'b1;
      expCtl("flushBusy", ctl(0,0,1,1,0,0,1,0,1), MK_ALL);
      cyc(); PCSrcE = 1'b0;
      expCtl("flushBusyDone", ctl(0,0,0,0,0,0,1,1,1), MK_ALL);
      cyc(); expCnt("flushBusyCnt", 16'd3, 16'd3);

      // Saturation of the stall counter
      for (int i = 0; i < 65540; i++) begin
         cyc();
         if (i == 0) begin
            LoadE = 1'b1; RdE = 6'd7; Rs1D = 6'd7;
         end
         if (i == 65531) expCnt("satNear", 16'd65534, 16'd3);
         if (i == 65535) expCnt("satTop", 16'd65535, 16'd3);
      end
      cyc(); clr();
      expCtl("satRelease", ctl(0,0,0,0,0,0,0,0,1), MK_ALL);
      expCnt("sat", 16'd65535, 16'd3);
      cyc(); expCnt("satHold", 16'd65535, 16'd3);

      cyc();
      cyc();
      if (sbQ.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", sbQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
